// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the writable instruction memory.
//   - state_e   : controller states (CLEAR sweep, RUN fetch, LOAD burst)
//   - insn_t    : field layout of a 24-bit instruction word
//   - NOP       : all-zero instruction, also the value written by the sweep
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Instruction field widths and bit offsets.
  localparam int INSN_W   = 24;
  localparam int IMM_W    = 16;
  localparam int IMM_LSB  = 8;
  localparam int ISEL_BIT = 7;
  localparam int A_W      = 2;
  localparam int A_LSB    = 5;
  localparam int B_W      = 2;
  localparam int B_LSB    = 3;
  localparam int OP_BIT   = 2;
  localparam int O_W      = 2;
  localparam int O_LSB    = 0;

  typedef struct packed {
    logic [IMM_W-1:0] imm;   // [23:8]
    logic             isel;  // [7]
    logic [A_W-1:0]   a;     // [6:5]
    logic [B_W-1:0]   b;     // [4:3]
    logic             op;    // [2]
    logic [O_W-1:0]   o;     // [1:0]
  } insn_t;

  localparam logic [INSN_W-1:0] NOP = 24'h000000;

  // Splits a raw word into its fields; handy for consumers of f_data.
  function automatic insn_t decode_insn(input logic [INSN_W-1:0] word);
    return insn_t'(word);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous RAM with registered read.
//   clk   : clock
//   we    : write enable; wdata stored at addr on the rising edge
//   addr  : shared read/write address
//   wdata : write data
//   rdata : mem[addr] as it was before this edge's write (read-first)
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/imem_prog.sv
// imem_prog: writable instruction memory with a fetch port and a
// valid/ready load port.
//   clk, rst_n          : clock, synchronous active-low reset
//   f_req/f_addr        : fetch request and address (accepted in RUN)
//   f_ready             : high in RUN only
//   f_valid/f_data      : fetched word, one cycle after an accepted fetch;
//                         f_data holds its last value between fetches
//   ld_start/ld_base    : open a load burst at ld_base (sampled in RUN)
//   ld_valid/ld_data/
//   ld_last/ld_ready    : load beats; ld_ready high in LOAD only
//   ld_done             : one-cycle pulse after the final beat is written
//   ld_count            : beats written in the current/last burst (saturating)
//   ld_wrap             : sticky, burst pointer passed DEPTH-1
// After reset the whole array is swept to zero before RUN is entered.
module imem_prog
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_wrap
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // Compared at ADDR_W+1 bits so DEPTH == 2**ADDR_W does not truncate to 0.
  localparam logic [CNT_W-1:0]  DEPTH_EXT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  ld_count_q, ld_count_d;
  logic              ld_wrap_q, ld_wrap_d;
  logic              ld_done_q, ld_done_d;
  logic              f_valid_q, f_valid_d;
  logic              f_oob_q, f_oob_d;
  logic [DATA_W-1:0] f_hold_q, f_hold_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] fetch_word;
  logic [ADDR_W-1:0] base_mod;

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Out-of-range fetches are flagged at accept time and forced to zero here,
  // since the RAM holds no such word.
  assign fetch_word = f_oob_q ? '0 : ram_rdata;
  // Between fetches the RAM read register keeps changing with the address
  // mux, so the last delivered word is held separately.
  assign f_data     = f_valid_q ? fetch_word : f_hold_q;
  assign base_mod   = ADDR_W'({1'b0, ld_base} % DEPTH_EXT);

  assign f_ready  = (state_q == ST_RUN);
  assign ld_ready = (state_q == ST_LOAD);
  assign f_valid  = f_valid_q;
  assign ld_done  = ld_done_q;
  assign ld_count = ld_count_q;
  assign ld_wrap  = ld_wrap_q;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wptr_d     = wptr_q;
    ld_count_d = ld_count_q;
    ld_wrap_d  = ld_wrap_q;
    ld_done_d  = 1'b0;
    f_valid_d  = 1'b0;
    f_oob_d    = f_oob_q;
    f_hold_d   = f_data;
    ram_we     = 1'b0;
    ram_addr   = f_addr;
    ram_wdata  = ld_data;

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_ptr_q;
        ram_wdata = DATA_W'(NOP);
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          clr_ptr_d = '0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        ram_addr = f_addr;
        if (f_req) begin
          f_valid_d = 1'b1;
          f_oob_d   = ({1'b0, f_addr} >= DEPTH_EXT);
        end
        // A fetch accepted alongside ld_start reads pre-load contents: the
        // RAM is addressed by f_addr this cycle and writes start next cycle.
        if (ld_start) begin
          state_d    = ST_LOAD;
          wptr_d     = base_mod;
          ld_count_d = '0;
          ld_wrap_d  = ({1'b0, ld_base} >= DEPTH_EXT);
        end
      end

      ST_LOAD: begin
        ram_addr  = wptr_q;
        ram_wdata = ld_data;
        if (ld_valid) begin
          ram_we = 1'b1;
          if (ld_count_q != CNT_MAX) begin
            ld_count_d = ld_count_q + 1'b1;
          end
          if (wptr_q == LAST_ADDR) begin
            wptr_d    = '0;
            ld_wrap_d = 1'b1;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
          if (ld_last) begin
            state_d   = ST_RUN;
            ld_done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      wptr_q     <= '0;
      ld_count_q <= '0;
      ld_wrap_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      f_valid_q  <= 1'b0;
      f_oob_q    <= 1'b0;
      f_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wptr_q     <= wptr_d;
      ld_count_q <= ld_count_d;
      ld_wrap_q  <= ld_wrap_d;
      ld_done_q  <= ld_done_d;
      f_valid_q  <= f_valid_d;
      f_oob_q    <= f_oob_d;
      f_hold_q   <= f_hold_d;
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog: directed + randomized bench for imem_prog. A plain array
// models memory contents; burst count/wrap expectations are computed from
// base address and beat total.
module tb_imem_prog;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_ready;
  logic        f_valid;
  logic [23:0] f_data;
  logic        ld_start;
  logic [7:0]  ld_base;
  logic        ld_valid;
  logic [23:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic [8:0]  ld_count;
  logic        ld_wrap;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [23:0] model_mem [DEPTH];
  logic [23:0] beat_q [$];
  logic [7:0]  addr_q [$];

  imem_prog dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_ready  (f_ready),
    .f_valid  (f_valid),
    .f_data   (f_data),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_count (ld_count),
    .ld_wrap  (ld_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] mrd(input int a);
    return (a >= DEPTH) ? 24'h0 : model_mem[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 24'h0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (f_ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check(tag, n, 256);
    $display("reset sweep: f_ready after %0d cycles", n);
  endtask

  // Back-to-back fetches of addr_q, then one idle cycle to check the hold.
  task automatic fetch_list(input string tag);
    logic [23:0] last = 24'h0;
    foreach (addr_q[k]) begin
      f_req  = 1'b1;
      f_addr = addr_q[k];
      tick();
      last = mrd(int'(addr_q[k]));
      check($sformatf("%s_valid@%02h", tag, addr_q[k]), f_valid, 1);
      check($sformatf("%s_data@%02h", tag, addr_q[k]), f_data, last);
      $display("fetch %02h -> %06h (model %06h)", addr_q[k], f_data, last);
    end
    f_req  = 1'b0;
    f_addr = 8'($urandom);
    tick();
    check({tag, "_idle_valid"}, f_valid, 0);
    check({tag, "_idle_hold"}, f_data, last);
  endtask

  // Burst of n beats from beat_q at base. mode 0: no stalls, mode 1: one
  // stall between beats with f_req held high, mode 2: random stalls with
  // stray ld_last. If fw is set a fetch of fa rides on the ld_start cycle.
  task automatic load_burst(input logic [7:0] base, input int n, input int mode,
                            input bit fw, input logic [7:0] fa);
    logic [23:0] exp_f;
    int ns;
    int exp_cnt;
    bit exp_wrap;
    exp_f    = mrd(int'(fa));
    ld_start = 1'b1;
    ld_base  = base;
    f_req    = fw;
    f_addr   = fa;
    tick();
    ld_start = 1'b0;
    ld_base  = 8'($urandom);
    check("ld_ready_after_start", ld_ready, 1);
    if (fw) begin
      check("start_fetch_valid", f_valid, 1);
      check("start_fetch_data", f_data, exp_f);
    end
    for (int i = 0; i < n; i++) begin
      ns = (mode == 0) ? 0 : (mode == 1) ? ((i > 0) ? 1 : 0) : $urandom_range(0, 2);
      repeat (ns) begin
        ld_valid = 1'b0;
        ld_last  = (mode == 2) ? 1'($urandom) : 1'b0;
        ld_data  = 24'($urandom);
        f_req    = (mode == 1) ? 1'b1 : 1'($urandom);
        f_addr   = 8'($urandom);
        tick();
        check("stall_ld_ready", ld_ready, 1);
        check("stall_f_valid", f_valid, 0);
        check("stall_f_ready", f_ready, 0);
      end
      ld_valid = 1'b1;
      ld_data  = beat_q[i];
      ld_last  = (i == n - 1);
      f_req    = (mode == 1) ? 1'b1 : 1'($urandom);
      f_addr   = 8'($urandom);
      tick();
      check("beat_f_valid", f_valid, 0);
      if (i < n - 1) begin
        check("beat_ld_ready", ld_ready, 1);
        check("beat_f_ready", f_ready, 0);
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    f_req    = 1'b0;
    for (int i = 0; i < n; i++) model_mem[(int'(base) + i) % DEPTH] = beat_q[i];
    exp_cnt  = (n > 256) ? 256 : n;
    exp_wrap = (int'(base) + n) >= DEPTH;
    check("done_pulse", ld_done, 1);
    check("done_count", ld_count, exp_cnt);
    check("done_wrap", ld_wrap, exp_wrap);
    check("done_f_ready", f_ready, 1);
    check("done_ld_ready", ld_ready, 0);
    $display("burst base=%02h n=%0d: count=%0d wrap=%0b done=%0b", base, n, ld_count, ld_wrap, ld_done);
    tick();
    check("done_once", ld_done, 0);
    check("count_hold", ld_count, exp_cnt);
  endtask

  task automatic rand_beats(input int n);
    beat_q = {};
    for (int i = 0; i < n; i++) beat_q.push_back(24'($urandom));
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = 8'h0; ld_start = 1'b0; ld_base = 8'h0;
    ld_valid = 1'b0; ld_data = 24'h0; ld_last = 1'b0;
    model_clear();

    // Reset state
    tick(); tick();
    check("rst_f_ready", f_ready, 0);
    check("rst_f_valid", f_valid, 0);
    check("rst_f_data", f_data, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_ld_done", ld_done, 0);
    check("rst_ld_count", ld_count, 0);
    check("rst_ld_wrap", ld_wrap, 0);
    rst_n = 1'b1;
    wait_ready("sweep_len");

    // Cleared memory reads zero
    addr_q = {8'h00, 8'h7F, 8'hFF};
    fetch_list("clr");

    // Directed 3-beat program at 0
    beat_q = {24'h000118, 24'h000119, 24'h00000E};
    load_burst(8'h00, 3, 0, 1'b0, 8'h00);
    addr_q = {8'h00, 8'h01, 8'h02, 8'h03};
    fetch_list("prog3");

    // Wrap past the top
    rand_beats(4);
    load_burst(8'hFE, 4, 0, 1'b0, 8'h00);
    addr_q = {8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    fetch_list("wrap4");

    // Stall in the middle, fetch requested every cycle
    rand_beats(2);
    load_burst(8'h30, 2, 1, 1'b0, 8'h00);
    addr_q = {8'h2F, 8'h30, 8'h31, 8'h32};
    fetch_list("stall");

    // Fetch riding on the ld_start cycle reads pre-load data
    beat_q = {24'h000120};
    load_burst(8'h05, 1, 0, 1'b0, 8'h00);
    rand_beats(2);
    load_burst(8'h40, 2, 2, 1'b1, 8'h05);
    addr_q = {8'h05, 8'h40, 8'h41};
    fetch_list("startfetch");

    // Randomized bursts followed by randomized fetches
    repeat (6) begin
      int n;
      logic [7:0] b;
      n = $urandom_range(1, 12);
      b = 8'($urandom);
      rand_beats(n);
      load_burst(b, n, 2, 1'($urandom), 8'($urandom));
      addr_q = {};
      for (int i = 0; i < 12; i++)
        addr_q.push_back((i < 6) ? 8'(int'(b) + i) : 8'($urandom));
      fetch_list("rand");
    end

    // Count saturates on an over-long burst
    rand_beats(300);
    load_burst(8'h80, 300, 0, 1'b0, 8'h00);
    addr_q = {8'h7F, 8'h80, 8'hFF, 8'h00, 8'h2B, 8'h2C};
    fetch_list("long");

    // Reset in the middle of a burst
    ld_start = 1'b1; ld_base = 8'h10;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 24'hA5A500 + 24'(i); ld_last = 1'b0;
      tick();
    end
    rst_n = 1'b0; ld_data = 24'hDEAD01;
    tick();
    ld_valid = 1'b0;
    check("abort_ld_done", ld_done, 0);
    check("abort_ld_ready", ld_ready, 0);
    check("abort_f_ready", f_ready, 0);
    check("abort_ld_count", ld_count, 0);
    check("abort_ld_wrap", ld_wrap, 0);
    rst_n = 1'b1;
    model_clear();
    wait_ready("resweep_len");
    addr_q = {8'h10, 8'h11, 8'h12, 8'h00, 8'h80};
    fetch_list("after_abort");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
